// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Req0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [2:0]       F0,
  output logic             Ack0,
  output logic             Done0,
  output logic [WIDTH-1:0] Y0,
  output logic             Zero0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic [2:0]       F1,
  output logic             Ack1,
  output logic             Done1,
  output logic [WIDTH-1:0] Y1,
  output logic             Zero1,
  output logic [WIDTH-1:0] Alu_A,
  output logic [WIDTH-1:0] Alu_B,
  output logic [2:0]       Alu_F,
  input  logic [WIDTH-1:0] Alu_Y,
  input  logic             Alu_Zero,
  output logic             Busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t     state, state_next;
  logic       pri;
  logic       owner;
  logic [3:0] cnt;
  logic       grant_valid;
  logic       grant_sel;
  logic       capture;

  // Requests are only looked at in IDLE; a tie goes to the requester named by pri.
  always_comb begin
    state_next  = state;
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          grant_valid = 1'b1;
          grant_sel   = (Req0 && Req1) ? pri : Req1;
          state_next  = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      pri   <= 1'b0;
      owner <= 1'b0;
      cnt   <= 4'd0;
      Ack0  <= 1'b0;
      Ack1  <= 1'b0;
      Done0 <= 1'b0;
      Done1 <= 1'b0;
      Y0    <= '0;
      Y1    <= '0;
      Zero0 <= 1'b0;
      Zero1 <= 1'b0;
      Alu_A <= '0;
      Alu_B <= '0;
      Alu_F <= 3'b000;
    end else begin
      Ack0  <= 1'b0;
      Ack1  <= 1'b0;
      Done0 <= 1'b0;
      Done1 <= 1'b0;
      if (grant_valid) begin
        Alu_A <= grant_sel ? A1 : A0;
        Alu_B <= grant_sel ? B1 : B0;
        Alu_F <= grant_sel ? F1 : F0;
        owner <= grant_sel;
        Ack0  <= ~grant_sel;
        Ack1  <= grant_sel;
        pri   <= ~grant_sel;
        cnt   <= CNT_INIT;
      end
      if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Only the owner's result registers move; the other side keeps its last value.
      if (capture) begin
        if (owner) begin
          Y1    <= Alu_Y;
          Zero1 <= Alu_Zero;
          Done1 <= 1'b1;
        end else begin
          Y0    <= Alu_Y;
          Zero0 <= Alu_Zero;
          Done0 <= 1'b1;
        end
      end
    end
  end

  assign Busy = (state == EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        Clock = 1'b0;
  logic        Resetn;

  logic        Req0, Req1;
  logic [31:0] A0, B0, A1, B1;
  logic [2:0]  F0, F1;
  logic        Ack0, Ack1, Done0, Done1, Zero0, Zero1, Busy;
  logic [31:0] Y0, Y1, Alu_A, Alu_B, Alu_Y;
  logic [2:0]  Alu_F;
  logic        Alu_Zero;

  logic        q_Req0, q_Req1;
  logic [31:0] q_A0, q_B0, q_A1, q_B1;
  logic [2:0]  q_F0, q_F1;
  logic        q_Ack0, q_Ack1, q_Done0, q_Done1, q_Zero0, q_Zero1, q_Busy;
  logic [31:0] q_Y0, q_Y1, q_Alu_A, q_Alu_B, q_Alu_Y;
  logic [2:0]  q_Alu_F;
  logic        q_Alu_Zero;

  int n_pass  = 0;
  int n_total = 0;

  logic        m_pri;
  logic [31:0] m_y [2];

  always #5 Clock = ~Clock;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    Alu_Y      = alu_fn(Alu_A, Alu_B, Alu_F);
    Alu_Zero   = (Alu_Y == 32'd0);
    q_Alu_Y    = alu_fn(q_Alu_A, q_Alu_B, q_Alu_F);
    q_Alu_Zero = (q_Alu_Y == 32'd0);
  end

  alu_arbiter #(.WIDTH(32), .LATENCY(1)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .Req0(Req0), .A0(A0), .B0(B0), .F0(F0), .Ack0(Ack0), .Done0(Done0), .Y0(Y0), .Zero0(Zero0),
    .Req1(Req1), .A1(A1), .B1(B1), .F1(F1), .Ack1(Ack1), .Done1(Done1), .Y1(Y1), .Zero1(Zero1),
    .Alu_A(Alu_A), .Alu_B(Alu_B), .Alu_F(Alu_F), .Alu_Y(Alu_Y), .Alu_Zero(Alu_Zero), .Busy(Busy)
  );

  alu_arbiter #(.WIDTH(32), .LATENCY(3)) dut3 (
    .Clock(Clock), .Resetn(Resetn),
    .Req0(q_Req0), .A0(q_A0), .B0(q_B0), .F0(q_F0), .Ack0(q_Ack0), .Done0(q_Done0), .Y0(q_Y0), .Zero0(q_Zero0),
    .Req1(q_Req1), .A1(q_A1), .B1(q_B1), .F1(q_F1), .Ack1(q_Ack1), .Done1(q_Done1), .Y1(q_Y1), .Zero1(q_Zero1),
    .Alu_A(q_Alu_A), .Alu_B(q_Alu_B), .Alu_F(q_Alu_F), .Alu_Y(q_Alu_Y), .Alu_Zero(q_Alu_Zero), .Busy(q_Busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        r0, r1;
    logic [31:0] a0, b0;
    logic [2:0]  f0;
    logic [31:0] a1, b1;
    logic [2:0]  f1;
    logic        k;
    logic [31:0] y;
    logic        z;
  } vec_t;

  // One complete transaction on the LATENCY=1 instance, entered and left at a negedge with the DUT idle.
  task automatic run_op(input vec_t v, input string tag);
    logic got;
    logic [31:0] ea;
    logic [2:0]  ef;
    got = 1'b0;
    ea = v.k ? v.a1 : v.a0;
    ef = v.k ? v.f1 : v.f0;
    Req0 = v.r0; Req1 = v.r1;
    A0 = v.a0; B0 = v.b0; F0 = v.f0;
    A1 = v.a1; B1 = v.b1; F1 = v.f1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      if (Ack0 || Ack1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk({tag, "_ack_timeout"}, 0, 1);
      Req0 = 1'b0; Req1 = 1'b0;
      return;
    end
    chk({tag, "_ack"}, {Ack1, Ack0}, v.k ? 2'b10 : 2'b01);
    chk({tag, "_busy"}, Busy, 1);
    Req0 = 1'b0; Req1 = 1'b0;
    @(negedge Clock);
    chk({tag, "_done"}, {Done1, Done0, Ack1, Ack0}, v.k ? 4'b1000 : 4'b0100);
    chk({tag, "_y"}, v.k ? Y1 : Y0, v.y);
    chk({tag, "_zero"}, v.k ? Zero1 : Zero0, v.z);
    chk({tag, "_other_y"}, v.k ? Y0 : Y1, m_y[!v.k]);
    chk({tag, "_alu_hold"}, {Alu_F, Alu_A}, {ef, ea});
    @(negedge Clock);
    chk({tag, "_done_pulse"}, {Done1, Done0, Busy}, 3'b000);
    m_pri     = !v.k;
    m_y[v.k]  = v.y;
  endtask

  vec_t tbl [8];
  logic [3:0] seq [8];
  logic [2:0] fsel [5];

  initial begin
    tbl[0] = '{1, 0, 32'h5, 32'h3, 3'b010, 32'h0, 32'h0, 3'b000, 0, 32'h8, 0};
    tbl[1] = '{0, 1, 32'h0, 32'h0, 3'b000, 32'h7, 32'h7, 3'b110, 1, 32'h0, 1};
    tbl[2] = '{1, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h0, 32'h0, 3'b000, 0, 32'h00F000F0, 0};
    tbl[3] = '{0, 1, 32'h0, 32'h0, 3'b000, 32'h12340000, 32'h00005678, 3'b001, 1, 32'h12345678, 0};
    tbl[4] = '{1, 0, 32'hFFFFFFFF, 32'h1, 3'b111, 32'h0, 32'h0, 3'b000, 0, 32'h1, 0};
    tbl[5] = '{1, 1, 32'h9, 32'h9, 3'b010, 32'h3, 32'h5, 3'b110, 1, 32'hFFFFFFFE, 0};
    tbl[6] = '{1, 1, 32'hFFFFFFFF, 32'h1, 3'b010, 32'h6, 32'h6, 3'b001, 0, 32'h0, 1};
    tbl[7] = '{0, 1, 32'h0, 32'h0, 3'b000, 32'h1, 32'hFFFFFFFF, 3'b111, 1, 32'h0, 1};
    fsel[0] = 3'b000; fsel[1] = 3'b001; fsel[2] = 3'b010; fsel[3] = 3'b110; fsel[4] = 3'b111;
    // {Ack0, Done0, Ack1, Done1} per cycle with both requests held
    seq[0] = 4'b1000; seq[1] = 4'b0100; seq[2] = 4'b0010; seq[3] = 4'b0001;
    seq[4] = 4'b1000; seq[5] = 4'b0100; seq[6] = 4'b0010; seq[7] = 4'b0001;

    Resetn = 1'b0;
    Req0 = 0; Req1 = 0; A0 = 0; B0 = 0; F0 = 0; A1 = 0; B1 = 0; F1 = 0;
    q_Req0 = 0; q_Req1 = 0; q_A0 = 0; q_B0 = 0; q_F0 = 0; q_A1 = 0; q_B1 = 0; q_F1 = 0;
    m_pri = 1'b0; m_y[0] = 32'd0; m_y[1] = 32'd0;
    repeat (2) @(negedge Clock);
    chk("reset_ctrl", {Ack0, Ack1, Done0, Done1, Zero0, Zero1, Busy}, 7'd0);
    chk("reset_y", {Y0, Y1}, 64'd0);
    chk("reset_alu", {Alu_F, Alu_A, Alu_B}, 67'd0);
    chk("reset3_ctrl", {q_Ack0, q_Ack1, q_Done0, q_Done1, q_Busy, q_Y0}, 37'd0);
    Resetn = 1'b1;
    @(negedge Clock);

    // LATENCY=3 instance: Done three cycles after Ack, Req1 raised mid-EXEC waits for IDLE
    q_Req0 = 1; q_A0 = 32'h0000000A; q_B0 = 32'h00000014; q_F0 = 3'b010;
    q_A1 = 32'h00000010; q_B1 = 32'h00000004; q_F1 = 3'b110;
    @(negedge Clock);
    chk("l3_ack0", {q_Ack0, q_Ack1, q_Busy, q_Done0}, 4'b1010);
    q_Req0 = 0; q_Req1 = 1;
    @(negedge Clock);
    chk("l3_c1", {q_Ack0, q_Ack1, q_Busy, q_Done0}, 4'b0010);
    @(negedge Clock);
    chk("l3_c2", {q_Ack0, q_Ack1, q_Busy, q_Done0}, 4'b0010);
    @(negedge Clock);
    chk("l3_c3_done", {q_Ack0, q_Ack1, q_Busy, q_Done0}, 4'b0001);
    chk("l3_y0", q_Y0, 32'h0000001E);
    @(negedge Clock);
    chk("l3_c4_ack1", {q_Ack0, q_Ack1, q_Busy, q_Done0}, 4'b0110);
    q_Req1 = 0;
    repeat (3) @(negedge Clock);
    chk("l3_done1", {q_Done1, q_Done0, q_Busy}, 3'b100);
    chk("l3_y1", {q_Y1, q_Zero1, q_Y0}, {32'h0000000C, 1'b0, 32'h0000001E});

    // Reset during EXEC drops the in-flight result
    Req0 = 1; A0 = 32'hFFFFFFFF; B0 = 32'h1; F0 = 3'b111;
    @(negedge Clock);
    chk("rst_mid_ack", {Ack0, Busy}, 2'b11);
    Resetn = 1'b0; Req0 = 0;
    @(negedge Clock);
    chk("rst_mid_ctrl", {Ack0, Ack1, Done0, Done1, Zero0, Zero1, Busy}, 7'd0);
    chk("rst_mid_data", {Y0, Y1, Alu_F, Alu_A}, 99'd0);
    Resetn = 1'b1;
    m_pri = 1'b0; m_y[0] = 32'd0; m_y[1] = 32'd0;
    run_op('{0, 1, 32'h0, 32'h0, 3'b000, 32'h2, 32'h3, 3'b010, 1, 32'h5, 0}, "post_rst");

    // Back-to-back with both requests held: grants alternate starting from requester 0
    if (m_pri == 1'b0) begin
      Req0 = 1; A0 = 32'h1; B0 = 32'h2; F0 = 3'b010;
      Req1 = 1; A1 = 32'hFFFFFFFF; B1 = 32'h1; F1 = 3'b010;
      for (int c = 0; c < 8; c++) begin
        @(negedge Clock);
        chk($sformatf("b2b_c%0d", c), {Ack0, Done0, Ack1, Done1}, seq[c]);
      end
      Req0 = 0; Req1 = 0;
      chk("b2b_y", {Y0, Zero0, Y1, Zero1}, {32'h3, 1'b0, 32'h0, 1'b1});
      @(negedge Clock);
      m_pri = 1'b0; m_y[0] = 32'h3; m_y[1] = 32'h0;
    end

    for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Random traffic against the round-robin model
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      logic [31:0] oa, ob;
      logic [2:0]  of;
      v.r0 = 1'($urandom_range(0, 1));
      v.r1 = 1'($urandom_range(0, 1));
      if (!v.r0 && !v.r1) v.r0 = 1'b1;
      v.a0 = $urandom; v.b0 = $urandom; v.f0 = fsel[$urandom_range(0, 4)];
      v.a1 = $urandom; v.b1 = $urandom; v.f1 = fsel[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) v.b0 = v.a0;
      if ($urandom_range(0, 3) == 0) v.b1 = v.a1;
      v.k = (v.r0 && v.r1) ? m_pri : v.r1;
      oa = v.k ? v.a1 : v.a0;
      ob = v.k ? v.b1 : v.b0;
      of = v.k ? v.f1 : v.f0;
      v.y = alu_fn(oa, ob, of);
      v.z = (v.y == 32'd0);
      run_op(v, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU (A, B, F[2:0] in; Y, Zero out) between two requesters.
- Round-robin arbitration, registered operand issue, and per-requester result return with one-cycle Done pulses.
- Sits between the ALU instance and the two client blocks that need arithmetic; the arbiter never interprets F.

Parameters:
- WIDTH, 32, operand/result width.
- LATENCY, 1, cycles in EXEC before the ALU result is captured (1..15); raised if the ALU is later pipelined.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  synchronous, active-low reset.
- Req0  in  1  requester 0 operation request; held until Ack0.
- A0  in  WIDTH  requester 0 operand A.
- B0  in  WIDTH  requester 0 operand B.
- F0  in  3  requester 0 ALU function.
- Ack0  out  1  one-cycle pulse: request 0 accepted, operands latched.
- Done0  out  1  one-cycle pulse: Y0/Zero0 updated.
- Y0  out  WIDTH  requester 0 result, held until the next Done0.
- Zero0  out  1  requester 0 zero flag, held until the next Done0.
- Req1, A1, B1, F1, Ack1, Done1, Y1, Zero1: identical set for requester 1.
- Alu_A  out  WIDTH  registered operand A to the ALU.
- Alu_B  out  WIDTH  registered operand B to the ALU.
- Alu_F  out  3  registered function code to the ALU.
- Alu_Y  in  WIDTH  ALU result.
- Alu_Zero  in  1  ALU zero flag.
- Busy  out  1  high while state is EXEC.

Behaviour:
- One clock (Clock). Synchronous active-low reset: Resetn=0 at a posedge forces:
  - state=IDLE, Pri=0, Cnt=0, Owner=0;
  - Ack0/1=0, Done0/1=0, Y0/Y1=0, Zero0/1=0;
  - Alu_A/Alu_B=0, Alu_F=000, Busy=0.
- Reset mid-operation discards the in-flight result: no Done is issued and no Y register is written.
- FSM IDLE:
  - Req0/Req1 are sampled only in IDLE.
  - If none asserted, stay in IDLE.
  - Otherwise grant k: the only requester asserted, or, if both are asserted, k=Pri.
  - At that posedge: Alu_A/B/F <= Ak/Bk/Fk; Owner <= k; Ackk <= 1; Pri <= ~k; Cnt <= LATENCY-1; state <= EXEC.
- FSM EXEC:
  - Ack returns to 0 after one cycle; Busy=1.
  - If Cnt!=0: Cnt <= Cnt-1.
  - Else, at that posedge: Y[Owner] <= Alu_Y; Zero[Owner] <= Alu_Zero; Done[Owner] <= 1; state <= IDLE.
  - Done lasts exactly one cycle.
- Timing and throughput:
  - Accept posedge to Done-asserting posedge = LATENCY cycles.
  - Next IDLE sample occurs one cycle later; throughput is one op per LATENCY+1 cycles.
- Requester rule: deassert Req after seeing Ack. A Req still high at the next IDLE sample counts as a new request (intentional back-to-back issue).
- Req changes during EXEC are ignored. The other requester's Y/Zero never change.
- Alu_A/B/F hold their last issued values in IDLE.
- Zero is passed through from the ALU, not recomputed.
- Width: Y registers are WIDTH bits; no extension or truncation.
- F codes pass through unchanged: 000 AND, 001 OR, 010 add, 110 subtract, 111 SLT.

Test Plan:
- Reset, then Req0 with A0=00000005, B0=00000003, F0=010 -> Ack0 one cycle after sample, Done0 next cycle; Y0=00000008, Zero0=0; Y1 stays 00000000.
- Req1 with A1=00000007, B1=00000007, F1=110 -> Y1=00000000, Zero1=1, Done1 single pulse, Done0 stays 0.
- Req0 and Req1 held high continuously, A0=1/B0=2/F0=010 and A1=FFFFFFFF/B1=00000001/F1=010 -> grants alternate 0,1,0,1 one per 2 cycles; Y0=00000003, Y1=00000000 with Zero1=1.
- Issue Req0 (F0=111, A0=FFFFFFFF, B0=00000001), assert Resetn=0 during EXEC -> no Done0; all outputs 0 next cycle; a fresh Req1 after reset is granted first (Pri=0, only requester).
- LATENCY=3: Req0 add 0000000A+00000014 -> Done0 exactly 3 cycles after Ack0's sample edge, Y0=0000001E; Busy high 3 cycles; Req1 raised mid-EXEC is not acked until IDLE.
